// File: rtl/banked_buffer.sv
// Multi-bank activation/weight buffer: HOST / PE-lockstep / BCAST modes, drain-then-switch mode handshake,
// two-cycle registered reads. Optional macro BANKED_BUFFER_WR_BYPASS_EN forwards same-edge write data to a read.
module banked_buffer #(
  parameter int N_BANK = 8,
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(N_BANK)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode_req,
  input  logic                      mode_req_valid,
  output logic                      mode_ack,
  output logic [1:0]                mode,
  output logic                      busy,
  output logic                      err,
  input  logic                      h_wr_en,
  input  logic [SW-1:0]             h_wr_sel,
  input  logic [AW-1:0]             h_wr_addr,
  input  logic [WIDTH-1:0]          h_wr_data,
  input  logic                      h_rd_en,
  input  logic [SW-1:0]             h_rd_sel,
  input  logic [AW-1:0]             h_rd_addr,
  output logic [WIDTH-1:0]          h_rd_data,
  output logic                      h_rd_valid,
  input  logic                      p_wr_en,
  input  logic [AW-1:0]             p_wr_addr,
  input  logic [N_BANK*WIDTH-1:0]   p_wr_bus,
  input  logic                      p_rd_en,
  input  logic [AW-1:0]             p_rd_addr,
  output logic [N_BANK*WIDTH-1:0]   p_rd_bus,
  output logic                      p_rd_valid
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_SWITCH} state_t;

  localparam logic [1:0]  M_HOST  = 2'd0;
  localparam logic [1:0]  M_PE    = 2'd1;
  localparam logic [1:0]  M_BCAST = 2'd2;
  localparam logic [1:0]  M_RSVD  = 2'd3;
  localparam logic [SW:0] NBANK_L = (SW+1)'(N_BANK);

  state_t                  state;
  logic [1:0]              pend_mode;
  logic                    active;
  logic                    h_wr_ok, h_rd_ok, p_wr_ok, p_rd_ok;
  logic                    acc_err, req_err;
  logic [AW-1:0]           wr_addr, rd_addr;
  logic                    s1_h_valid, s1_p_valid;
  logic [SW-1:0]           s1_sel;
  logic [N_BANK*WIDTH-1:0] s1_bus;

  // Access legality: anything not accepted in the current mode/state is dropped and flags err.
  always_comb begin
    active  = (state == ST_ACTIVE) && !rst;
    h_wr_ok = active && h_wr_en &&
              ((mode == M_BCAST) || ((mode == M_HOST) && ({1'b0, h_wr_sel} < NBANK_L)));
    h_rd_ok = active && h_rd_en && ((mode == M_HOST) || (mode == M_BCAST)) &&
              ({1'b0, h_rd_sel} < NBANK_L);
    p_wr_ok = active && p_wr_en && (mode == M_PE);
    p_rd_ok = active && p_rd_en && (mode == M_PE);
    acc_err = (h_wr_en && !h_wr_ok) || (h_rd_en && !h_rd_ok) ||
              (p_wr_en && !p_wr_ok) || (p_rd_en && !p_rd_ok);
    req_err = mode_req_valid && (!active || (mode_req == M_RSVD));
    wr_addr = (mode == M_PE) ? p_wr_addr : h_wr_addr;
    rd_addr = (mode == M_PE) ? p_rd_addr : h_rd_addr;
  end

  for (genvar i = 0; i < N_BANK; i++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] word_q;
    logic             wr_en_i, rd_en_i;
    logic [WIDTH-1:0] wr_data_i;

    assign wr_en_i   = p_wr_ok || (h_wr_ok && ((mode == M_BCAST) || (h_wr_sel == SW'(i))));
    assign rd_en_i   = p_rd_ok || (h_rd_ok && (h_rd_sel == SW'(i)));
    assign wr_data_i = (mode == M_PE) ? p_wr_bus[i*WIDTH +: WIDTH] : h_wr_data;

    always_ff @(posedge clk) begin
      if (wr_en_i)
        mem[wr_addr] <= wr_data_i;
      if (rd_en_i) begin
`ifdef BANKED_BUFFER_WR_BYPASS_EN
        if (wr_en_i && (wr_addr == rd_addr))
          word_q <= wr_data_i;
        else
          word_q <= mem[rd_addr];
`else
        word_q <= mem[rd_addr];
`endif
      end
    end

    assign s1_bus[i*WIDTH +: WIDTH] = word_q;
  end

  // Read pipeline plus mode FSM; DRAIN exits once the first stage is empty so the output
  // stage has emptied by the time SWITCH raises mode_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACTIVE;
      mode       <= M_HOST;
      pend_mode  <= M_HOST;
      mode_ack   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      s1_h_valid <= 1'b0;
      s1_p_valid <= 1'b0;
      s1_sel     <= '0;
      h_rd_valid <= 1'b0;
      p_rd_valid <= 1'b0;
      h_rd_data  <= '0;
      p_rd_bus   <= '0;
    end else begin
      s1_h_valid <= h_rd_ok;
      s1_p_valid <= p_rd_ok;
      if (h_rd_ok)
        s1_sel <= h_rd_sel;
      h_rd_valid <= s1_h_valid;
      p_rd_valid <= s1_p_valid;
      if (s1_h_valid)
        h_rd_data <= s1_bus[s1_sel*WIDTH +: WIDTH];
      if (s1_p_valid)
        p_rd_bus <= s1_bus;
      if (acc_err || req_err)
        err <= 1'b1;
      mode_ack <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (mode_req_valid && (mode_req != M_RSVD)) begin
            state     <= ST_DRAIN;
            pend_mode <= mode_req;
            busy      <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!s1_h_valid && !s1_p_valid) begin
            state    <= ST_SWITCH;
            mode     <= pend_mode;
            mode_ack <= 1'b1;
          end
        end
        ST_SWITCH: begin
          state <= ST_ACTIVE;
          busy  <= 1'b0;
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_buffer.sv
// Directed bench for banked_buffer: reference memory model plus read-expectation queues
// checked every cycle at the falling edge.
`timescale 1ns/1ps
module tb_banked_buffer;

  localparam int N_BANK = 6;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int SW     = 3;
  localparam int BW     = N_BANK * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode_req;
  logic              mode_req_valid;
  logic              mode_ack;
  logic [1:0]        mode;
  logic              busy;
  logic              err;
  logic              h_wr_en;
  logic [SW-1:0]     h_wr_sel;
  logic [AW-1:0]     h_wr_addr;
  logic [WIDTH-1:0]  h_wr_data;
  logic              h_rd_en;
  logic [SW-1:0]     h_rd_sel;
  logic [AW-1:0]     h_rd_addr;
  logic [WIDTH-1:0]  h_rd_data;
  logic              h_rd_valid;
  logic              p_wr_en;
  logic [AW-1:0]     p_wr_addr;
  logic [BW-1:0]     p_wr_bus;
  logic              p_rd_en;
  logic [AW-1:0]     p_rd_addr;
  logic [BW-1:0]     p_rd_bus;
  logic              p_rd_valid;

  banked_buffer #(.N_BANK(N_BANK), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_ack(mode_ack),
    .mode(mode), .busy(busy), .err(err),
    .h_wr_en(h_wr_en), .h_wr_sel(h_wr_sel), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .h_rd_en(h_rd_en), .h_rd_sel(h_rd_sel), .h_rd_addr(h_rd_addr),
    .h_rd_data(h_rd_data), .h_rd_valid(h_rd_valid),
    .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr), .p_wr_bus(p_wr_bus),
    .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr), .p_rd_bus(p_rd_bus), .p_rd_valid(p_rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    int            due;
  } exp_t;

  exp_t             h_q[$];
  exp_t             p_q[$];
  logic [WIDTH-1:0] model [N_BANK][DEPTH];
  int               cyc    = 0;
  int               passed = 0;
  int               total  = 0;

  task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expected);
    total++;
    assert (obs === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expected);
  endtask

  task automatic monitor();
    logic hv, pv;
    exp_t e;
    hv = (h_q.size() > 0) && (h_q[0].due == cyc);
    pv = (p_q.size() > 0) && (p_q[0].due == cyc);
    checkOutput("h_rd_valid", BW'(h_rd_valid), BW'(hv));
    checkOutput("p_rd_valid", BW'(p_rd_valid), BW'(pv));
    if (hv) begin
      e = h_q.pop_front();
      if (h_rd_valid === 1'b1) checkOutput("h_rd_data", BW'(h_rd_data), e.data);
    end
    if (pv) begin
      e = p_q.pop_front();
      if (p_rd_valid === 1'b1) checkOutput("p_rd_bus", p_rd_bus, e.data);
    end
  endtask

  // One clock: inputs set before the call are sampled at the rising edge, outputs checked at the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    monitor();
    h_wr_en = 1'b0; h_rd_en = 1'b0; p_wr_en = 1'b0; p_rd_en = 1'b0; mode_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic host_wr(input int sel, input int addr, input logic [WIDTH-1:0] d);
    h_wr_en = 1'b1; h_wr_sel = SW'(sel); h_wr_addr = AW'(addr); h_wr_data = d;
    model[sel][addr] = d;
    applyStimulus();
  endtask

  task automatic host_rd(input int sel, input int addr);
    exp_t e;
    h_rd_en = 1'b1; h_rd_sel = SW'(sel); h_rd_addr = AW'(addr);
    e.data = BW'(model[sel][addr]); e.due = cyc + 2;
    h_q.push_back(e);
    applyStimulus();
  endtask

  task automatic bcast_wr(input int addr, input logic [WIDTH-1:0] d);
    h_wr_en = 1'b1; h_wr_sel = SW'(7); h_wr_addr = AW'(addr); h_wr_data = d;
    for (int b = 0; b < N_BANK; b++) model[b][addr] = d;
    applyStimulus();
  endtask

  task automatic pe_wr(input int addr, input logic [WIDTH-1:0] base);
    p_wr_en = 1'b1; p_wr_addr = AW'(addr);
    for (int b = 0; b < N_BANK; b++) begin
      p_wr_bus[b*WIDTH +: WIDTH] = base + WIDTH'(b);
      model[b][addr] = base + WIDTH'(b);
    end
    applyStimulus();
  endtask

  task automatic pe_rd(input int addr);
    exp_t e;
    p_rd_en = 1'b1; p_rd_addr = AW'(addr);
    for (int b = 0; b < N_BANK; b++) e.data[b*WIDTH +: WIDTH] = model[b][addr];
    e.due = cyc + 2;
    p_q.push_back(e);
    applyStimulus();
  endtask

  task automatic request(input logic [1:0] m);
    mode_req = m; mode_req_valid = 1'b1;
    applyStimulus();
    checkOutput("busy_after_req", BW'(busy), BW'(1'b1));
  endtask

  task automatic wait_ack(input logic [1:0] m);
    int k = 0;
    while (mode_ack !== 1'b1 && k < 8) begin
      applyStimulus();
      k++;
    end
    checkOutput("mode_ack_seen", BW'(mode_ack), BW'(1'b1));
    checkOutput("mode_at_ack", BW'(mode), BW'(m));
    checkOutput("h_valid_at_ack", BW'(h_rd_valid), BW'(1'b0));
    applyStimulus();
    checkOutput("ack_one_cycle", BW'(mode_ack), BW'(1'b0));
    checkOutput("busy_cleared", BW'(busy), BW'(1'b0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; mode_req = 2'd0; mode_req_valid = 1'b0;
    h_wr_en = 1'b0; h_wr_sel = '0; h_wr_addr = '0; h_wr_data = '0;
    h_rd_en = 1'b0; h_rd_sel = '0; h_rd_addr = '0;
    p_wr_en = 1'b0; p_wr_addr = '0; p_wr_bus = '0; p_rd_en = 1'b0; p_rd_addr = '0;
    idle(2);
    checkOutput("rst_mode", BW'(mode), BW'(2'd0));
    checkOutput("rst_busy", BW'(busy), BW'(1'b0));
    checkOutput("rst_err", BW'(err), BW'(1'b0));
    checkOutput("rst_ack", BW'(mode_ack), BW'(1'b0));
    checkOutput("rst_h_data", BW'(h_rd_data), BW'(0));
    checkOutput("rst_p_bus", p_rd_bus, BW'(0));
    rst = 1'b0;

    // HOST single-bank access, other banks keep their own words
    for (int j = 0; j < N_BANK; j++) host_wr(j, 5, 16'hA000 + WIDTH'(j));
    host_wr(3, 5, 16'h1234);
    for (int j = 0; j < N_BANK; j++) host_rd(j, 5);
    idle(3);
    checkOutput("host_err_clean", BW'(err), BW'(1'b0));

    // Same-edge read and write of bank 2 addr 9
    host_wr(2, 9, 16'h0001);
    h_wr_en = 1'b1; h_wr_sel = 3'd2; h_wr_addr = 5'd9; h_wr_data = 16'h0002;
    h_rd_en = 1'b1; h_rd_sel = 3'd2; h_rd_addr = 5'd9;
`ifdef BANKED_BUFFER_WR_BYPASS_EN
    e.data = BW'(16'h0002);
`else
    e.data = BW'(16'h0001);
`endif
    e.due = cyc + 2;
    h_q.push_back(e);
    model[2][9] = 16'h0002;
    applyStimulus();
    host_rd(2, 9);
    idle(3);

    // BCAST: out-of-range select is ignored for writes in this mode
    request(2'd2);
    wait_ack(2'd2);
    bcast_wr(7, 16'hBEEF);
    host_rd(4, 7);
    idle(3);
    checkOutput("bcast_err_clean", BW'(err), BW'(1'b0));

    // Switch to PE with a host read in flight; PE enable while busy is dropped
    host_rd(0, 7);
    mode_req = 2'd1; mode_req_valid = 1'b1;
    applyStimulus();
    checkOutput("busy_inflight", BW'(busy), BW'(1'b1));
    p_rd_en = 1'b1; p_rd_addr = 5'd7;
    applyStimulus();
    wait_ack(2'd1);
    checkOutput("err_busy_access", BW'(err), BW'(1'b1));

    // PE lockstep access
    pe_rd(7);
    pe_wr(0, 16'h0100);
    pe_wr(1, 16'h0200);
    pe_rd(0);
    pe_rd(1);
    pe_rd(0);
    pe_rd(7);
    idle(3);

    pulse_reset();
    checkOutput("rst2_err", BW'(err), BW'(1'b0));
    checkOutput("rst2_mode", BW'(mode), BW'(2'd0));
    checkOutput("rst2_p_bus", p_rd_bus, BW'(0));

    // Reserved mode request
    mode_req = 2'd3; mode_req_valid = 1'b1;
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      checkOutput("rsvd_no_ack", BW'(mode_ack), BW'(1'b0));
      checkOutput("rsvd_mode", BW'(mode), BW'(2'd0));
      checkOutput("rsvd_busy", BW'(busy), BW'(1'b0));
      applyStimulus();
    end
    checkOutput("rsvd_err", BW'(err), BW'(1'b1));

    // Out-of-range host read select: no valid, err set; memory survives reset
    pulse_reset();
    h_rd_en = 1'b1; h_rd_sel = 3'd6; h_rd_addr = 5'd5;
    applyStimulus();
    idle(3);
    checkOutput("badsel_err", BW'(err), BW'(1'b1));
    pulse_reset();
    host_rd(3, 5);
    idle(3);

    // Request while busy is ignored and flags err
    request(2'd2);
    mode_req = 2'd1; mode_req_valid = 1'b1;
    applyStimulus();
    wait_ack(2'd2);
    checkOutput("busy_req_err", BW'(err), BW'(1'b1));

    // Reset during drain aborts the switch
    request(2'd1);
    pulse_reset();
    checkOutput("abort_mode", BW'(mode), BW'(2'd0));
    checkOutput("abort_busy", BW'(busy), BW'(1'b0));
    for (int k = 0; k < 3; k++) begin
      checkOutput("abort_no_ack", BW'(mode_ack), BW'(1'b0));
      applyStimulus();
    end
    checkOutput("abort_mode_final", BW'(mode), BW'(2'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
